// File: rtl/py_txacl_bufq_pkg.sv
`default_nettype none
// ============================================================================
// Module : py_txacl_bufq_pkg
// Brief  : Shared bank-state encoding and error-pulse constants for the
//          TX ACL bank ring.
// Rev    : 1.0  initial release
// ============================================================================
package py_txacl_bufq_pkg;

    typedef enum logic {
        BANK_FREE = 1'b0,
        BANK_FULL = 1'b1
    } bank_state_e;

    // Error pulse vector: one bit per error kind
    localparam int ERR_W       = 2;
    localparam int ERR_OVF_BIT = 0;
    localparam int ERR_UDF_BIT = 1;
    localparam logic [ERR_W-1:0] ERR_NONE = 2'b00;

endpackage
`default_nettype wire

// File: rtl/py_txacl_bufq_sram_1p.sv
`default_nettype none
// ============================================================================
// Module : sram_1p
// Brief  : Single-port synchronous RAM, one-cycle registered read.
// Rev    : 1.0  initial release
// ============================================================================
module sram_1p #(
    parameter int AW = 8,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          i_cs,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_din,
    output logic [DW-1:0] o_dout
);

    logic [DW-1:0] r_mem [2**AW];
    logic [DW-1:0] r_dout;

    always_ff @(posedge clk) begin
        if (i_cs) begin
            if (i_we) begin
                r_mem[i_addr] <= i_din;
            end else begin
                r_dout <= r_mem[i_addr];
            end
        end
    end

    assign o_dout = r_dout;

endmodule
`default_nettype wire

// File: rtl/py_txacl_bufq.sv
`default_nettype none
// ============================================================================
// Module : py_txacl_bufq
// Brief  : Ring of NBANK payload banks between the baseband writer and the
//          link controller reader, with ACK/NAK release and ACL SEQN tracking.
// Rev    : 1.0  initial release
// ============================================================================
module py_txacl_bufq
    import py_txacl_bufq_pkg::*;
#(
    parameter int NBANK = 2,
    parameter int AW    = 8,
    parameter int DW    = 32
) (
    input  logic                       clk_6M,
    input  logic                       rst,
    input  logic [AW-1:0]              wr_addr,
    input  logic [DW-1:0]              wr_din,
    input  logic                       wr_we,
    input  logic                       wr_cs,
    input  logic                       wr_commit,
    input  logic [AW:0]                wr_len,
    output logic                       wr_ready,
    input  logic [AW-1:0]              rd_addr,
    input  logic                       rd_cs,
    output logic [DW-1:0]              rd_dout,
    output logic                       rd_avail,
    output logic [AW:0]                rd_len,
    input  logic                       tx_done,
    input  logic                       tx_ack,
    input  logic                       flush,
    output logic                       txaclSEQN,
    output logic [$clog2(NBANK+1)-1:0] level,
    output logic                       ovf_err,
    output logic                       udf_err
);

    localparam int PW = $clog2(NBANK);
    localparam int LW = $clog2(NBANK+1);

    bank_state_e     r_state [NBANK];
    logic [AW:0]     r_len   [NBANK];
    logic [PW-1:0]   r_wb;
    logic [PW-1:0]   r_rb;
    logic [LW-1:0]   r_level;
    logic            r_seqn;
    logic [ERR_W-1:0] r_err;
    logic            r_rd_pend;
    logic [PW-1:0]   r_rd_bank;
    logic [DW-1:0]   r_rd_dout;
    logic [DW-1:0]   w_bank_dout [NBANK];

    logic w_wr_ready;
    logic w_rd_avail;
    logic w_wr_go;
    logic w_rd_go;
    logic w_commit;
    logic w_release;

    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
        return (p == PW'(NBANK-1)) ? '0 : p + PW'(1);
    endfunction

    assign w_wr_ready = (r_state[r_wb] == BANK_FREE);
    assign w_rd_avail = (r_state[r_rb] == BANK_FULL);
    assign w_wr_go    = wr_we & wr_cs & w_wr_ready;
    assign w_rd_go    = rd_cs & w_rd_avail;
    assign w_commit   = wr_commit & w_wr_ready;
    assign w_release  = tx_done & tx_ack & w_rd_avail;

    always_ff @(posedge clk_6M) begin
        if (rst) begin
            for (int i = 0; i < NBANK; i++) begin
                r_state[i] <= BANK_FREE;
                r_len[i]   <= '0;
            end
            r_wb    <= '0;
            r_rb    <= '0;
            r_level <= '0;
            r_seqn  <= 1'b1;
            r_err   <= ERR_NONE;
        end else if (flush) begin
            for (int i = 0; i < NBANK; i++) begin
                r_state[i] <= BANK_FREE;
                r_len[i]   <= '0;
            end
            r_wb    <= '0;
            r_rb    <= '0;
            r_level <= '0;
            r_err   <= ERR_NONE;
        end else begin
            // Commit and release never target the same bank: one needs FREE, the other FULL
            if (w_commit) begin
                r_state[r_wb] <= BANK_FULL;
                r_len[r_wb]   <= wr_len;
                r_wb          <= f_inc(r_wb);
            end
            if (w_release) begin
                r_state[r_rb] <= BANK_FREE;
                r_rb          <= f_inc(r_rb);
                r_seqn        <= ~r_seqn;
            end
            if (w_commit && !w_release) begin
                r_level <= r_level + LW'(1);
            end else if (!w_commit && w_release) begin
                r_level <= r_level - LW'(1);
            end
            r_err[ERR_OVF_BIT] <= wr_commit & ~w_wr_ready;
            r_err[ERR_UDF_BIT] <= tx_done & ~w_rd_avail;
        end
    end

    always_ff @(posedge clk_6M) begin
        if (rst) begin
            r_rd_pend <= 1'b0;
            r_rd_bank <= '0;
            r_rd_dout <= '0;
        end else begin
            r_rd_pend <= w_rd_go;
            r_rd_bank <= r_rb;
            if (r_rd_pend) begin
                r_rd_dout <= w_bank_dout[r_rd_bank];
            end
        end
    end

    generate
        for (genvar i = 0; i < NBANK; i++) begin : g_bank
            logic w_wsel;
            logic w_rsel;
            logic w_cs;
            logic w_we;

            // A bank is write-owned only while FREE at wb, read-owned only while FULL at rb
            assign w_wsel = w_wr_ready & (r_wb == PW'(i));
            assign w_rsel = w_rd_avail & (r_rb == PW'(i));
            assign w_we   = w_wsel & w_wr_go;
            assign w_cs   = w_we | (w_rsel & w_rd_go);

            sram_1p #(
                .AW (AW),
                .DW (DW)
            ) u_ram (
                .clk    (clk_6M),
                .i_cs   (w_cs),
                .i_we   (w_we),
                .i_addr (w_wsel ? wr_addr : rd_addr),
                .i_din  (wr_din),
                .o_dout (w_bank_dout[i])
            );
        end
    endgenerate

    assign wr_ready  = w_wr_ready;
    assign rd_avail  = w_rd_avail;
    assign rd_len    = w_rd_avail ? r_len[r_rb] : '0;
    assign rd_dout   = r_rd_dout;
    assign txaclSEQN = r_seqn;
    assign level     = r_level;
    assign ovf_err   = r_err[ERR_OVF_BIT];
    assign udf_err   = r_err[ERR_UDF_BIT];

endmodule
`default_nettype wire

// File: tb/tb_py_txacl_bufq.sv
`default_nettype none
// ============================================================================
// Module : tb_py_txacl_bufq
// Brief  : Two ring sizes (2 and 4 banks) on shared stimulus, checked against
//          a bank-ring reference model plus directed literal expectations.
// ============================================================================
module tb_py_txacl_bufq;

    logic        clk = 1'b0;
    logic        rst, wr_we, wr_cs, wr_commit, rd_cs, tx_done, tx_ack, flush;
    logic [7:0]  wr_addr, rd_addr;
    logic [31:0] wr_din;
    logic [8:0]  wr_len;

    logic        o2_wr_ready, o2_rd_avail, o2_seqn, o2_ovf, o2_udf;
    logic [31:0] o2_rd_dout;
    logic [8:0]  o2_rd_len;
    logic [1:0]  o2_level;
    logic        o4_wr_ready, o4_rd_avail, o4_seqn, o4_ovf, o4_udf;
    logic [31:0] o4_rd_dout;
    logic [8:0]  o4_rd_len;
    logic [2:0]  o4_level;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    py_txacl_bufq #(.NBANK(2), .AW(8), .DW(32)) u_dut2 (
        .clk_6M(clk), .rst(rst), .wr_addr(wr_addr), .wr_din(wr_din), .wr_we(wr_we),
        .wr_cs(wr_cs), .wr_commit(wr_commit), .wr_len(wr_len), .wr_ready(o2_wr_ready),
        .rd_addr(rd_addr), .rd_cs(rd_cs), .rd_dout(o2_rd_dout), .rd_avail(o2_rd_avail),
        .rd_len(o2_rd_len), .tx_done(tx_done), .tx_ack(tx_ack), .flush(flush),
        .txaclSEQN(o2_seqn), .level(o2_level), .ovf_err(o2_ovf), .udf_err(o2_udf)
    );

    py_txacl_bufq #(.NBANK(4), .AW(8), .DW(32)) u_dut4 (
        .clk_6M(clk), .rst(rst), .wr_addr(wr_addr), .wr_din(wr_din), .wr_we(wr_we),
        .wr_cs(wr_cs), .wr_commit(wr_commit), .wr_len(wr_len), .wr_ready(o4_wr_ready),
        .rd_addr(rd_addr), .rd_cs(rd_cs), .rd_dout(o4_rd_dout), .rd_avail(o4_rd_avail),
        .rd_len(o4_rd_len), .tx_done(tx_done), .tx_ack(tx_ack), .flush(flush),
        .txaclSEQN(o4_seqn), .level(o4_level), .ovf_err(o4_ovf), .udf_err(o4_udf)
    );

    // ---------------- reference model (index 0: 2 banks, 1: 4 banks) ----------
    bit          m_full [2][8];
    int          m_len  [2][8];
    int          m_wb[2], m_rb[2], m_lvl[2];
    bit          m_seq[2], m_ovf[2], m_udf[2];
    logic [31:0] m_mem [2][8][256];
    bit          m_mv  [2][8][256];
    bit          m_pend[2], m_pk[2], m_dk[2];
    logic [31:0] m_pdata[2], m_dout[2];

    task automatic model_step(input int k);
        int nb;
        bit rdy, av;
        nb = (k == 0) ? 2 : 4;
        if (rst) begin
            for (int b = 0; b < 8; b++) begin
                m_full[k][b] = 1'b0;
                m_len[k][b]  = 0;
                for (int a = 0; a < 256; a++) m_mv[k][b][a] = 1'b0;
            end
            m_wb[k] = 0; m_rb[k] = 0; m_lvl[k] = 0; m_seq[k] = 1'b1;
            m_ovf[k] = 1'b0; m_udf[k] = 1'b0; m_pend[k] = 1'b0;
            m_dout[k] = 32'h0; m_dk[k] = 1'b1;
            return;
        end
        rdy = !m_full[k][m_wb[k]];
        av  = m_full[k][m_rb[k]];
        if (m_pend[k]) begin
            m_dout[k] = m_pdata[k];
            m_dk[k]   = m_pk[k];
        end
        m_pend[k] = rd_cs && av;
        if (m_pend[k]) begin
            m_pdata[k] = m_mem[k][m_rb[k]][rd_addr];
            m_pk[k]    = m_mv[k][m_rb[k]][rd_addr];
        end
        if (wr_cs && wr_we && rdy) begin
            m_mem[k][m_wb[k]][wr_addr] = wr_din;
            m_mv[k][m_wb[k]][wr_addr]  = 1'b1;
        end
        m_ovf[k] = wr_commit && !rdy && !flush;
        m_udf[k] = tx_done && !av && !flush;
        if (flush) begin
            for (int b = 0; b < 8; b++) begin
                m_full[k][b] = 1'b0;
                m_len[k][b]  = 0;
            end
            m_wb[k] = 0; m_rb[k] = 0; m_lvl[k] = 0;
        end else begin
            if (tx_done && tx_ack && av) begin
                m_full[k][m_rb[k]] = 1'b0;
                m_rb[k]  = (m_rb[k] + 1) % nb;
                m_lvl[k] = m_lvl[k] - 1;
                m_seq[k] = !m_seq[k];
            end
            if (wr_commit && rdy) begin
                m_full[k][m_wb[k]] = 1'b1;
                m_len[k][m_wb[k]]  = int'(wr_len);
                m_wb[k]  = (m_wb[k] + 1) % nb;
                m_lvl[k] = m_lvl[k] + 1;
            end
        end
    endtask

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_inst(input int k, input string p, input logic rdy, input logic av,
                            input logic [8:0] len, input logic [31:0] dout, input logic seq,
                            input logic [2:0] lvl, input logic ovf, input logic udf);
        bit eav;
        eav = m_full[k][m_rb[k]];
        chk({p, ".wr_ready"}, 64'(rdy), 64'(!m_full[k][m_wb[k]]));
        chk({p, ".rd_avail"}, 64'(av), 64'(eav));
        chk({p, ".rd_len"},   64'(len), eav ? 64'(m_len[k][m_rb[k]]) : 64'd0);
        chk({p, ".seqn"},     64'(seq), 64'(m_seq[k]));
        chk({p, ".level"},    64'(lvl), 64'(m_lvl[k]));
        chk({p, ".ovf_err"},  64'(ovf), 64'(m_ovf[k]));
        chk({p, ".udf_err"},  64'(udf), 64'(m_udf[k]));
        if (m_dk[k]) chk({p, ".rd_dout"}, 64'(dout), 64'(m_dout[k]));
    endtask

    always begin
        @(posedge clk);
        #1;
        cmp_inst(0, "n2", o2_wr_ready, o2_rd_avail, o2_rd_len, o2_rd_dout, o2_seqn,
                 {1'b0, o2_level}, o2_ovf, o2_udf);
        cmp_inst(1, "n4", o4_wr_ready, o4_rd_avail, o4_rd_len, o4_rd_dout, o4_seqn,
                 o4_level, o4_ovf, o4_udf);
    end

    // ---------------- directed stimulus helpers ----------------
    task automatic idle();
        wr_we = 0; wr_cs = 0; wr_commit = 0; rd_cs = 0; tx_done = 0; tx_ack = 0; flush = 0;
    endtask

    task automatic pulse_commit(input int len);
        wr_commit = 1; wr_len = 9'(len);
        @(negedge clk);
        wr_commit = 0;
    endtask

    task automatic pulse_tx(input logic ack);
        tx_done = 1; tx_ack = ack;
        @(negedge clk);
        tx_done = 0; tx_ack = 0;
    endtask

    task automatic pulse_flush();
        flush = 1;
        @(negedge clk);
        flush = 0;
    endtask

    task automatic rd_chk(input int addr, input logic [31:0] exp, input string nm);
        rd_cs = 1; rd_addr = 8'(addr);
        @(negedge clk);
        rd_cs = 0;
        @(negedge clk);
        chk({nm, ".n2"}, 64'(o2_rd_dout), 64'(exp));
        chk({nm, ".n4"}, 64'(o4_rd_dout), 64'(exp));
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, ".wr_ready"}, 64'(o2_wr_ready & o4_wr_ready), 64'd1);
        chk({nm, ".rd_avail"}, 64'(o2_rd_avail | o4_rd_avail), 64'd0);
        chk({nm, ".rd_len"},   64'(o2_rd_len | o4_rd_len), 64'd0);
        chk({nm, ".rd_dout"},  64'(o2_rd_dout | o4_rd_dout), 64'd0);
        chk({nm, ".seqn"},     64'(o2_seqn & o4_seqn), 64'd1);
        chk({nm, ".level"},    64'({1'b0, o2_level} | o4_level), 64'd0);
        chk({nm, ".err"},      64'(o2_ovf | o2_udf | o4_ovf | o4_udf), 64'd0);
    endtask

    initial begin
        logic exp_seq;
        idle();
        rst = 1; wr_addr = 0; rd_addr = 0; wr_din = 0; wr_len = 0;
        repeat (2) @(negedge clk);
        rst = 0;
        chk_reset_vals("reset");

        // Single packet A0..A3, length 4
        for (int i = 0; i < 4; i++) begin
            wr_cs = 1; wr_we = 1; wr_addr = 8'(i); wr_din = 32'hA0 + 32'(i);
            @(negedge clk);
        end
        wr_cs = 0; wr_we = 0;
        pulse_commit(4);
        chk("pkt.avail", 64'(o2_rd_avail), 64'd1);
        chk("pkt.len",   64'(o2_rd_len), 64'd4);
        chk("pkt.level", 64'(o2_level), 64'd1);
        for (int i = 0; i < 4; i++) rd_chk(i, 32'hA0 + 32'(i), $sformatf("rd%0d", i));
        @(negedge clk);
        chk("rd.hold", 64'(o2_rd_dout), 64'hA3);

        // NAK three times, then ACK
        for (int i = 0; i < 3; i++) begin
            pulse_tx(1'b0);
            chk("nak.seqn",  64'(o2_seqn), 64'd1);
            chk("nak.avail", 64'(o2_rd_avail), 64'd1);
        end
        rd_chk(2, 32'hA2, "nak.rd");
        pulse_tx(1'b1);
        chk("ack.seqn",  64'(o2_seqn), 64'd0);
        chk("ack.level", 64'(o2_level), 64'd0);
        chk("ack.avail", 64'(o2_rd_avail), 64'd0);

        // Fill the 4-bank ring, then overflow
        pulse_flush();
        for (int j = 0; j < 5; j++) begin
            pulse_commit(10 + j);
            if (j == 3) begin
                chk("fill.ready4", 64'(o4_wr_ready), 64'd0);
                chk("fill.ovf4",   64'(o4_ovf), 64'd0);
            end
        end
        chk("ovf.pulse4", 64'(o4_ovf), 64'd1);
        chk("ovf.level4", 64'(o4_level), 64'd4);
        chk("ovf.ready4", 64'(o4_wr_ready), 64'd0);
        chk("ovf.level2", 64'(o2_level), 64'd2);

        // Release one, then concurrent commit+release across the wrap
        pulse_tx(1'b1);
        chk("rel.level4", 64'(o4_level), 64'd3);
        chk("rel.len4",   64'(o4_rd_len), 64'd11);
        chk("rel.ready4", 64'(o4_wr_ready), 64'd1);
        for (int j = 0; j < 6; j++) begin
            wr_commit = 1; wr_len = 9'(20 + j); tx_done = 1; tx_ack = 1;
            @(negedge clk);
            idle();
            chk("conc.level4", 64'(o4_level), 64'd3);
        end
        chk("wrap.len4", 64'(o4_rd_len), 64'd23);

        // Underflow on empty ring, then flush with two FULL banks
        pulse_flush();
        pulse_tx(1'b1);
        chk("udf.pulse4", 64'(o4_udf), 64'd1);
        chk("udf.pulse2", 64'(o2_udf), 64'd1);
        chk("udf.level4", 64'(o4_level), 64'd0);
        @(negedge clk);
        chk("udf.clear4", 64'(o4_udf), 64'd0);
        pulse_commit(5);
        pulse_commit(6);
        chk("pre.level4", 64'(o4_level), 64'd2);
        exp_seq = m_seq[1];
        pulse_flush();
        chk("flush.level4", 64'(o4_level), 64'd0);
        chk("flush.avail4", 64'(o4_rd_avail), 64'd0);
        chk("flush.seqn4",  64'(o4_seqn), 64'(exp_seq));

        // Reset in the middle of a write burst
        pulse_commit(7);
        wr_cs = 1; wr_we = 1; wr_addr = 8'd5; wr_din = 32'hDEAD;
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0; idle();
        chk_reset_vals("midrst");

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            rst       = ($urandom_range(0, 199) == 0);
            flush     = ($urandom_range(0, 49) == 0);
            wr_cs     = $urandom_range(0, 1);
            wr_we     = $urandom_range(0, 1);
            wr_addr   = 8'($urandom_range(0, 7));
            wr_din    = $urandom;
            wr_commit = ($urandom_range(0, 5) == 0);
            wr_len    = 9'($urandom);
            rd_cs     = $urandom_range(0, 1);
            rd_addr   = 8'($urandom_range(0, 7));
            tx_done   = ($urandom_range(0, 4) == 0);
            tx_ack    = ($urandom_range(0, 9) < 7);
            @(negedge clk);
        end
        rst = 0; idle();
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
